fireboy_sprite_fetch: RTL and testbench
=======================================

Name: fireboy_sprite_fetch

Overview:
Upstream address-generation and pixel-qualification stage for the 60x60 palette sprite ROMs (Fireboy_still and sibling animation ROMs).
- Takes the VGA beam position (DrawX/DrawY) and the character's latched screen position, and produces the 12-bit ROM read_address.
- Captures the ROM's 24-bit colour, applies the transparency key, and outputs an opaque flag for the colour mapper.
- Adds horizontal mirroring for facing direction and a frame-rate animation index that selects among the ROM instances.

Parameters:
SPR_W, 60, sprite width in pixels
SPR_H, 60, sprite height in pixels
ADDR_W, 12, ROM address width (must hold SPR_W*SPR_H-1 = 3599)
KEY_COLOR, 24'h800080, palette entry 0 colour, treated as transparent
NUM_FRAMES, 4, number of animation ROMs cycled through
FRAME_DIV, 6, video frames per animation step

Ports:
Clk  in  1  system/pixel clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pixel_valid  in  1  DrawX/DrawY is in the visible region
DrawX  in  10  beam column, 0..639
DrawY  in  10  beam row, 0..479
SpriteX  in  10  sprite top-left column (sampled on frame_start)
SpriteY  in  10  sprite top-left row (sampled on frame_start)
facing_left  in  1  mirror sprite horizontally (sampled on frame_start)
moving  in  1  enables animation (sampled on frame_start)
read_address  out  ADDR_W  address to sprite ROM
rom_pixel  in  24  pixel_color returned combinationally by the ROM
anim_frame  out  2  selects which animation ROM drives rom_pixel
pix_out  out  24  qualified sprite colour
pix_opaque  out  1  1 = draw pix_out, 0 = show background

Behaviour:
- Clock is Clk; reset is asynchronous, active-low (Reset_n).
- Reset state:
  - read_address = 0, pix_out = 0, pix_opaque = 0, anim_frame = 0.
  - All pipeline valid/in-box bits = 0.
  - Latched position, facing and moving = 0; animation counter = 0.
- Frame latch: on a cycle with frame_start = 1, register SpriteX, SpriteY, facing_left and moving. Between pulses, input changes have no effect, so there is no mid-frame tearing. New values apply from the next cycle.
- Stage 1 (cycle N+1):
  - Compute in_box = pixel_valid AND DrawX >= SX AND DrawX < SX+SPR_W AND DrawY >= SY AND DrawY < SY+SPR_H.
  - Sums are evaluated at 11 bits, so a sprite near the right/bottom edge never wraps. A partially off-screen sprite is simply clipped.
  - Register in_box, rel_x = DrawX-SX and rel_y = DrawY-SY (6 bits each, valid only when in_box).
- Stage 2 (cycle N+2):
  - col = facing ? (SPR_W-1-rel_x) : rel_x.
  - read_address <= rel_y*SPR_W + col, computed at ADDR_W bits; range 0..3599.
  - When in_box = 0, read_address <= 0.
  - Register the in_box bit alongside.
- Stage 3 (cycle N+3):
  - pix_out <= rom_pixel (sampled while read_address is stable).
  - pix_opaque <= in_box AND (rom_pixel != KEY_COLOR).
  - When pix_opaque = 0, pix_out is forced to 0.
- Total latency: DrawX/DrawY to pix_out/pix_opaque is exactly 3 cycles, fully pipelined with one pixel per clock. The colour mapper delays its background path by 3 to match.
- Animation, evaluated on frame_start using the newly sampled moving:
  - moving = 0: counter <= 0 and anim_frame <= 0.
  - moving = 1 and counter == FRAME_DIV-1: counter <= 0 and anim_frame <= (anim_frame+1) mod NUM_FRAMES.
  - Otherwise: counter++.
- anim_frame changes only on frame_start. It is held stable through the visible region, so the ROM mux never switches mid-frame.
- If frame_start and pixel_valid are both 1 in the same cycle, the pixel uses the previous latched position. There is no stall and no backpressure.
- Reset asserted mid-operation clears the pipeline immediately. The first pixel after release produces pix_opaque = 0 until three valid cycles have elapsed.

Test Plan:
1. Hold Reset_n = 0, toggle inputs, then release -> all outputs stay 0; anim_frame = 0 until the first qualifying frame_start sequence.
2. Pulse frame_start with SpriteX = 100, SpriteY = 200, facing = 0, then drive DrawX/DrawY = (100,200), (159,259), (160,259) -> read_address = 0, 3599, 0 at N+2; pix_opaque = 1, 1, 0 at N+3 when rom_pixel = 24'hEF2108.
3. Mirror: facing_left = 1, same position, pixel (100,200) -> read_address = 59; pixel (159,201) -> read_address = 60.
4. Transparency: in-box pixel with rom_pixel = 24'h800080 -> pix_opaque = 0 and pix_out = 0; rom_pixel = 24'h000000 -> pix_opaque = 1 and pix_out = 0.
5. Animation with moving = 1:
   - 6 frame_start pulses -> anim_frame = 1.
   - 24 pulses -> wraps to 0.
   - Drop moving, then one pulse -> anim_frame = 0 and counter = 0.
6. Change SpriteX to 300 mid-frame without frame_start -> addressing still uses 100. Next frame_start -> pixel (300,200) gives read_address = 0. Sprite at SpriteX = 620 -> pixel (639,200) gives address 19, and no wrap to column 0.

Source files
------------

// File: rtl/fireboy_sprite_fetch_if.sv
// Sprite fetch bus: beam position, per-frame sprite controls, the ROM
// address/data pair and the qualified pixel going to the colour mapper.
//   master : video timing / character logic / ROM / colour mapper side
//   slave  : fireboy_sprite_fetch
// Signals:
//   frame_start  one-cycle pulse at start of vertical blank
//   pixel_valid  DrawX/DrawY inside the visible region
//   DrawX/DrawY  beam column/row
//   SpriteX/Y    sprite top-left corner (latched on frame_start)
//   facing_left  horizontal mirror (latched on frame_start)
//   moving       animation enable (latched on frame_start)
//   read_address sprite ROM address
//   rom_pixel    colour returned combinationally by the ROM
//   anim_frame   animation ROM select
//   pix_out      qualified sprite colour (0 when transparent)
//   pix_opaque   1 = draw pix_out, 0 = show background
interface fireboy_sprite_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              frame_start;
  logic              pixel_valid;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        SpriteX;
  logic [9:0]        SpriteY;
  logic              facing_left;
  logic              moving;
  logic [ADDR_W-1:0] read_address;
  logic [23:0]       rom_pixel;
  logic [1:0]        anim_frame;
  logic [23:0]       pix_out;
  logic              pix_opaque;

  modport master (
    output frame_start, pixel_valid, DrawX, DrawY, SpriteX, SpriteY,
           facing_left, moving, rom_pixel,
    input  read_address, anim_frame, pix_out, pix_opaque
  );

  modport slave (
    input  frame_start, pixel_valid, DrawX, DrawY, SpriteX, SpriteY,
           facing_left, moving, rom_pixel,
    output read_address, anim_frame, pix_out, pix_opaque
  );
endinterface

// File: rtl/fireboy_sprite_fetch.sv
// Address generation and pixel qualification for the 60x60 palette sprite
// ROMs. A three-stage pipeline turns the beam position into a ROM address,
// then captures the returned colour and applies the transparency key.
// Horizontal mirroring and a frame-rate animation index are included.
// Ports:
//   Clk      system/pixel clock
//   Reset_n  asynchronous active-low reset
//   bus      fireboy_sprite_fetch_if.slave (see interface header)
// Latency DrawX/DrawY -> pix_out/pix_opaque is exactly 3 cycles.
module fireboy_sprite_fetch #(
  parameter int          SPR_W      = 60,
  parameter int          SPR_H      = 60,
  parameter int          ADDR_W     = 12,
  parameter logic [23:0] KEY_COLOR  = 24'h800080,
  parameter int          NUM_FRAMES = 4,
  parameter int          FRAME_DIV  = 6
) (
  input logic                    Clk,
  input logic                    Reset_n,
  fireboy_sprite_fetch_if.slave  bus
);

  localparam int REL_XW = $clog2(SPR_W);
  localparam int REL_YW = $clog2(SPR_H);
  localparam int CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  // Per-frame latched controls
  logic [9:0]       sx;
  logic [9:0]       sy;
  logic             facing;
  logic             moving_q;
  logic [CNT_W-1:0] anim_cnt;
  logic [1:0]       anim_frame_q;

  // Stage 1
  logic              in_box1;
  logic [REL_XW-1:0] rel_x1;
  logic [REL_YW-1:0] rel_y1;
  logic              facing1;

  // Stage 2
  logic              in_box2;
  logic [ADDR_W-1:0] read_address_q;

  // Stage 3
  logic [23:0]       pix_out_q;
  logic              pix_opaque_q;

  // Combinational helpers
  logic [10:0]       x_lo, x_hi, y_lo, y_hi, dx, dy;
  logic              in_box_c;
  logic [REL_XW-1:0] col_c;
  logic [ADDR_W-1:0] addr_c;
  logic              opaque_c;

  // Frame latch and animation index. The animation decision uses the
  // freshly sampled moving, not the previous frame's value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx           <= '0;
      sy           <= '0;
      facing       <= 1'b0;
      moving_q     <= 1'b0;
      anim_cnt     <= '0;
      anim_frame_q <= '0;
    end else if (bus.frame_start) begin
      sx       <= bus.SpriteX;
      sy       <= bus.SpriteY;
      facing   <= bus.facing_left;
      moving_q <= bus.moving;
      if (!bus.moving) begin
        anim_cnt     <= '0;
        anim_frame_q <= '0;
      end else if (anim_cnt == CNT_W'(FRAME_DIV - 1)) begin
        anim_cnt <= '0;
        if (anim_frame_q == 2'(NUM_FRAMES - 1))
          anim_frame_q <= '0;
        else
          anim_frame_q <= anim_frame_q + 2'd1;
      end else begin
        anim_cnt <= anim_cnt + CNT_W'(1);
      end
    end
  end

  // Box test at 11 bits so a sprite near the right/bottom edge cannot wrap.
  always_comb begin
    dx       = {1'b0, bus.DrawX};
    dy       = {1'b0, bus.DrawY};
    x_lo     = {1'b0, sx};
    y_lo     = {1'b0, sy};
    x_hi     = x_lo + 11'(SPR_W);
    y_hi     = y_lo + 11'(SPR_H);
    in_box_c = bus.pixel_valid && (dx >= x_lo) && (dx < x_hi)
               && (dy >= y_lo) && (dy < y_hi);
  end

  // Stage 1 registers. Facing travels with the pixel so that a frame_start
  // landing mid-pipeline cannot mirror a pixel addressed with the old
  // position.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box1 <= 1'b0;
      rel_x1  <= '0;
      rel_y1  <= '0;
      facing1 <= 1'b0;
    end else begin
      in_box1 <= in_box_c;
      rel_x1  <= REL_XW'(bus.DrawX - sx);
      rel_y1  <= REL_YW'(bus.DrawY - sy);
      facing1 <= facing;
    end
  end

  always_comb begin
    col_c  = facing1 ? (REL_XW'(SPR_W - 1) - rel_x1) : rel_x1;
    addr_c = ADDR_W'(rel_y1) * ADDR_W'(SPR_W) + ADDR_W'(col_c);
  end

  // Stage 2 registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box2        <= 1'b0;
      read_address_q <= '0;
    end else begin
      in_box2        <= in_box1;
      read_address_q <= in_box1 ? addr_c : '0;
    end
  end

  // Stage 3: ROM data is combinational off read_address_q.
  assign opaque_c = in_box2 && (bus.rom_pixel != KEY_COLOR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_opaque_q <= 1'b0;
      pix_out_q    <= '0;
    end else begin
      pix_opaque_q <= opaque_c;
      pix_out_q    <= opaque_c ? bus.rom_pixel : '0;
    end
  end

  assign bus.read_address = read_address_q;
  assign bus.anim_frame   = anim_frame_q;
  assign bus.pix_out      = pix_out_q;
  assign bus.pix_opaque   = pix_opaque_q;

endmodule

// File: tb/tb_fireboy_sprite_fetch.sv
// Directed bench for fireboy_sprite_fetch with hand-computed expectations.
module tb_fireboy_sprite_fetch;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  fireboy_sprite_fetch_if #(.ADDR_W(12)) bus ();

  fireboy_sprite_fetch #(
    .SPR_W(60), .SPR_H(60), .ADDR_W(12), .KEY_COLOR(24'h800080),
    .NUM_FRAMES(4), .FRAME_DIV(6)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame(input logic [9:0] x, input logic [9:0] y,
                       input logic face, input logic mov);
    bus.SpriteX     = x;
    bus.SpriteY     = y;
    bus.facing_left = face;
    bus.moving      = mov;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // One isolated pixel: address checked 2 cycles later, pixel 3 cycles later.
  task automatic run_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [23:0] rom, input logic [11:0] exp_addr,
                           input logic exp_opq, input logic [23:0] exp_pix);
    bus.DrawX       = x;
    bus.DrawY       = y;
    bus.pixel_valid = 1'b1;
    bus.rom_pixel   = rom;
    tick();
    bus.pixel_valid = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    tick();
    check({tag, "_addr"}, 32'(bus.read_address), 32'(exp_addr));
    tick();
    check({tag, "_opq"}, 32'(bus.pix_opaque), 32'(exp_opq));
    check({tag, "_pix"}, 32'(bus.pix_out), 32'(exp_pix));
  endtask

  logic [9:0]  sx_v [3];
  logic [9:0]  sy_v [3];
  logic [11:0] ea_v [3];
  logic        eo_v [3];

  initial begin
    bus.frame_start = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.SpriteX     = '0;
    bus.SpriteY     = '0;
    bus.facing_left = 1'b0;
    bus.moving      = 1'b0;
    bus.rom_pixel   = 24'hEF2108;

    // 1. Reset held while inputs toggle
    for (int i = 0; i < 8; i++) begin
      bus.frame_start = i[0];
      bus.moving      = 1'b1;
      bus.pixel_valid = 1'b1;
      bus.DrawX       = 10'(i);
      bus.DrawY       = 10'(i);
      tick();
    end
    check("rst_addr", 32'(bus.read_address), 0);
    check("rst_opq", 32'(bus.pix_opaque), 0);
    check("rst_pix", 32'(bus.pix_out), 0);
    check("rst_anim", 32'(bus.anim_frame), 0);
    bus.frame_start = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.moving      = 1'b0;
    Reset_n = 1'b1;
    tick();
    tick();
    check("rel_opq", 32'(bus.pix_opaque), 0);
    check("rel_anim", 32'(bus.anim_frame), 0);

    // 2. Streaming pixels back to back
    frame(10'd100, 10'd200, 1'b0, 1'b0);
    sx_v = '{10'd100, 10'd159, 10'd160};
    sy_v = '{10'd200, 10'd259, 10'd259};
    ea_v = '{12'd0, 12'd3599, 12'd0};
    eo_v = '{1'b1, 1'b1, 1'b0};
    bus.rom_pixel   = 24'hEF2108;
    bus.DrawX       = sx_v[0];
    bus.DrawY       = sy_v[0];
    bus.pixel_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c >= 1) check($sformatf("str_addr%0d", c - 1), 32'(bus.read_address), 32'(ea_v[c-1]));
      if (c >= 2) begin
        check($sformatf("str_opq%0d", c - 2), 32'(bus.pix_opaque), 32'(eo_v[c-2]));
        check($sformatf("str_pix%0d", c - 2), 32'(bus.pix_out),
              eo_v[c-2] ? 32'h00EF2108 : 32'h0);
      end
      if (c < 2) begin
        bus.DrawX = sx_v[c+1];
        bus.DrawY = sy_v[c+1];
      end else begin
        bus.pixel_valid = 1'b0;
      end
    end

    // 3. Mirror
    frame(10'd100, 10'd200, 1'b1, 1'b0);
    run_pixel("mir0", 10'd100, 10'd200, 24'hEF2108, 12'd59, 1'b1, 24'hEF2108);
    run_pixel("mir1", 10'd159, 10'd201, 24'hEF2108, 12'd60, 1'b1, 24'hEF2108);

    // 4. Transparency key
    frame(10'd100, 10'd200, 1'b0, 1'b0);
    run_pixel("key", 10'd110, 10'd205, 24'h800080, 12'd310, 1'b0, 24'h0);
    run_pixel("blk", 10'd110, 10'd205, 24'h000000, 12'd310, 1'b1, 24'h0);
    run_pixel("col", 10'd101, 10'd200, 24'h123456, 12'd1, 1'b1, 24'h123456);

    // 5. Animation
    for (int p = 1; p <= 24; p++) begin
      frame(10'd100, 10'd200, 1'b0, 1'b1);
      if (p == 5)  check("anim5", 32'(bus.anim_frame), 0);
      if (p == 6)  check("anim6", 32'(bus.anim_frame), 1);
      if (p == 12) check("anim12", 32'(bus.anim_frame), 2);
      if (p == 18) check("anim18", 32'(bus.anim_frame), 3);
      if (p == 24) check("anim24", 32'(bus.anim_frame), 0);
    end
    for (int p = 1; p <= 3; p++) frame(10'd100, 10'd200, 1'b0, 1'b1);
    frame(10'd100, 10'd200, 1'b0, 1'b0);
    check("anim_stop", 32'(bus.anim_frame), 0);
    // Counter must have restarted: 5 pulses stay at 0, the 6th steps to 1
    for (int p = 1; p <= 6; p++) begin
      frame(10'd100, 10'd200, 1'b0, 1'b1);
      if (p == 5) check("cnt_clr5", 32'(bus.anim_frame), 0);
      if (p == 6) check("cnt_clr6", 32'(bus.anim_frame), 1);
    end
    frame(10'd100, 10'd200, 1'b0, 1'b0);
    // anim_frame must not move without frame_start
    bus.moving = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("anim_hold", 32'(bus.anim_frame), 0);
    bus.moving = 1'b0;

    // 6. Frame latch, right/bottom edge clipping
    bus.SpriteX = 10'd300;
    run_pixel("latch_old", 10'd101, 10'd200, 24'hEF2108, 12'd1, 1'b1, 24'hEF2108);
    run_pixel("latch_out", 10'd300, 10'd200, 24'hEF2108, 12'd0, 1'b0, 24'h0);
    frame(10'd300, 10'd200, 1'b0, 1'b0);
    run_pixel("latch_new", 10'd300, 10'd200, 24'hEF2108, 12'd0, 1'b1, 24'hEF2108);
    frame(10'd620, 10'd200, 1'b0, 1'b0);
    run_pixel("edge_r", 10'd639, 10'd200, 24'hEF2108, 12'd19, 1'b1, 24'hEF2108);
    run_pixel("edge_nowrap", 10'd5, 10'd200, 24'hEF2108, 12'd0, 1'b0, 24'h0);
    run_pixel("edge_left", 10'd619, 10'd200, 24'hEF2108, 12'd0, 1'b0, 24'h0);
    frame(10'd620, 10'd450, 1'b0, 1'b0);
    run_pixel("edge_b", 10'd620, 10'd479, 24'hEF2108, 12'd1740, 1'b1, 24'hEF2108);
    run_pixel("edge_bwrap", 10'd620, 10'd5, 24'hEF2108, 12'd0, 1'b0, 24'h0);

    // frame_start coinciding with a pixel uses the previous position
    frame(10'd100, 10'd200, 1'b0, 1'b0);
    bus.SpriteX     = 10'd400;
    bus.frame_start = 1'b1;
    run_pixel("fs_same", 10'd102, 10'd200, 24'hEF2108, 12'd2, 1'b1, 24'hEF2108);
    bus.frame_start = 1'b0;

    // Reset mid-operation clears the pipeline immediately
    frame(10'd100, 10'd200, 1'b0, 1'b0);
    bus.DrawX       = 10'd105;
    bus.DrawY       = 10'd200;
    bus.pixel_valid = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_opq", 32'(bus.pix_opaque), 1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_opq", 32'(bus.pix_opaque), 0);
    check("mid_rst_addr", 32'(bus.read_address), 0);
    Reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_opq", 32'(bus.pix_opaque), 0);
    bus.pixel_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
